// File: rtl/mem_bus_arbiter_if.sv
// mem_bus_arbiter_if: CPU port, IO port and memory-side signals of mem_bus_arbiter.
// The slave modport is the arbiter's view; the master modport is the requesters' and memory's view.
interface mem_bus_arbiter_if #(
  parameter int AW = 32,
  parameter int DW = 32
);
  logic          cpu_req;
  logic          cpu_we;
  logic [AW-1:0] cpu_addr;
  logic [DW-1:0] cpu_wdata;
  logic [DW-1:0] cpu_rdata;
  logic          cpu_ready;
  logic          io_req;
  logic          io_we;
  logic [AW-1:0] io_addr;
  logic [DW-1:0] io_wdata;
  logic [DW-1:0] io_rdata;
  logic          io_ready;
  logic          mem_we;
  logic [AW-1:0] mem_addr;
  logic [DW-1:0] mem_wdata;
  logic [DW-1:0] mem_rdata;
  logic          owner_io;

  modport slave (
    input  cpu_req, cpu_we, cpu_addr, cpu_wdata,
    input  io_req, io_we, io_addr, io_wdata,
    input  mem_rdata,
    output cpu_rdata, cpu_ready, io_rdata, io_ready,
    output mem_we, mem_addr, mem_wdata, owner_io
  );

  modport master (
    output cpu_req, cpu_we, cpu_addr, cpu_wdata,
    output io_req, io_we, io_addr, io_wdata,
    output mem_rdata,
    input  cpu_rdata, cpu_ready, io_rdata, io_ready,
    input  mem_we, mem_addr, mem_wdata, owner_io
  );
endinterface

// File: rtl/mem_bus_arbiter.sv
// mem_bus_arbiter: shares one memory port between the CPU and an IO/DMA engine, one access per grant.
// Define ARB_ROUND_ROBIN_EN to replace CPU priority with starvation guard by round-robin arbitration.
module mem_bus_arbiter #(
  parameter int AW         = 32,
  parameter int DW         = 32,
  parameter int MEM_LAT    = 1,
  parameter int STARVE_MAX = 4
) (
  input logic              clk,
  input logic              reset,
  mem_bus_arbiter_if.slave bus
);
  typedef enum logic [1:0] {
    S_IDLE      = 2'd0,
    S_GRANT_CPU = 2'd1,
    S_GRANT_IO  = 2'd2,
    S_DONE      = 2'd3
  } state_t;

  localparam logic [3:0] LAT_INIT = 4'(MEM_LAT);
`ifndef ARB_ROUND_ROBIN_EN
  localparam logic [3:0] STARVE_LIM = 4'(STARVE_MAX);
`endif

  state_t        r_state;
  logic [3:0]    r_lat_cnt;
  logic          r_wr;
  logic          r_mem_we;
  logic [AW-1:0] r_mem_addr;
  logic [DW-1:0] r_mem_wdata;
  logic [DW-1:0] r_cpu_rdata;
  logic [DW-1:0] r_io_rdata;
  logic          r_cpu_ready;
  logic          r_io_ready;
  logic          r_owner_io;
`ifdef ARB_ROUND_ROBIN_EN
  logic          r_last_io;
`else
  logic [3:0]    r_starve_cnt;
`endif

  logic w_grant_any;
  logic w_grant_io;

  assign w_grant_any = bus.cpu_req | bus.io_req;

  // IO wins when alone, or on a tie when the policy hands it the turn
  always_comb begin
    w_grant_io = 1'b0;
`ifdef ARB_ROUND_ROBIN_EN
    if (bus.io_req && (!bus.cpu_req || !r_last_io)) begin
      w_grant_io = 1'b1;
    end else begin
      w_grant_io = 1'b0;
    end
`else
    if (bus.io_req && (!bus.cpu_req || (r_starve_cnt == STARVE_LIM))) begin
      w_grant_io = 1'b1;
    end else begin
      w_grant_io = 1'b0;
    end
`endif
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      r_state     <= S_IDLE;
      r_lat_cnt   <= 4'd0;
      r_wr        <= 1'b0;
      r_mem_we    <= 1'b0;
      r_mem_addr  <= {AW{1'b0}};
      r_mem_wdata <= {DW{1'b0}};
      r_cpu_rdata <= {DW{1'b0}};
      r_io_rdata  <= {DW{1'b0}};
      r_cpu_ready <= 1'b0;
      r_io_ready  <= 1'b0;
      r_owner_io  <= 1'b0;
`ifdef ARB_ROUND_ROBIN_EN
      r_last_io   <= 1'b1;
`else
      r_starve_cnt <= 4'd0;
`endif
    end else begin
      r_mem_we    <= 1'b0;
      r_cpu_ready <= 1'b0;
      r_io_ready  <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (w_grant_any) begin
            r_state     <= w_grant_io ? S_GRANT_IO : S_GRANT_CPU;
            r_owner_io  <= w_grant_io;
            r_wr        <= w_grant_io ? bus.io_we    : bus.cpu_we;
            r_mem_we    <= w_grant_io ? bus.io_we    : bus.cpu_we;
            r_mem_addr  <= w_grant_io ? bus.io_addr  : bus.cpu_addr;
            r_mem_wdata <= w_grant_io ? bus.io_wdata : bus.cpu_wdata;
            r_lat_cnt   <= LAT_INIT;
          end
`ifdef ARB_ROUND_ROBIN_EN
          if (w_grant_any) begin
            r_last_io <= w_grant_io;
          end
`else
          // Saturating count of CPU wins while IO is kept waiting
          if (!bus.io_req || w_grant_io) begin
            r_starve_cnt <= 4'd0;
          end else if (bus.cpu_req && (r_starve_cnt != STARVE_LIM)) begin
            r_starve_cnt <= r_starve_cnt + 4'd1;
          end
`endif
        end
        S_GRANT_CPU, S_GRANT_IO: begin
          if (r_lat_cnt == 4'd0) begin
            r_state <= S_DONE;
            if (r_owner_io) begin
              r_io_ready <= 1'b1;
              if (!r_wr) begin
                r_io_rdata <= bus.mem_rdata;
              end
            end else begin
              r_cpu_ready <= 1'b1;
              if (!r_wr) begin
                r_cpu_rdata <= bus.mem_rdata;
              end
            end
          end else begin
            r_lat_cnt <= r_lat_cnt - 4'd1;
          end
        end
        S_DONE: begin
          r_state    <= S_IDLE;
          r_owner_io <= 1'b0;
        end
        default: begin
          r_state    <= S_IDLE;
          r_owner_io <= 1'b0;
        end
      endcase
    end
  end

  assign bus.cpu_rdata = r_cpu_rdata;
  assign bus.cpu_ready = r_cpu_ready;
  assign bus.io_rdata  = r_io_rdata;
  assign bus.io_ready  = r_io_ready;
  assign bus.mem_we    = r_mem_we;
  assign bus.mem_addr  = r_mem_addr;
  assign bus.mem_wdata = r_mem_wdata;
  assign bus.owner_io  = r_owner_io;
endmodule

// File: tb/tb_mem_bus_arbiter.sv
// tb_mem_bus_arbiter: three arbiters (MEM_LAT 1, 3, 15) driven by directed accesses, checked each cycle
// against an access-level model of the arbitration rules, plus hand-computed literal expectations.
module tb_mem_bus_arbiter;
  localparam int N      = 3;
  localparam int STARVE = 4;

  function automatic int lat_of(input int i);
    return (i == 0) ? 1 : ((i == 1) ? 3 : 15);
  endfunction

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  logic        cpu_req_v [N];
  logic        io_req_v  [N];
  logic        cpu_we, io_we;
  logic [31:0] cpu_addr, cpu_wdata, io_addr, io_wdata;

  logic        d_cpu_ready [N];
  logic        d_io_ready  [N];
  logic        d_mem_we    [N];
  logic        d_owner     [N];
  logic [31:0] d_cpu_rdata [N];
  logic [31:0] d_io_rdata  [N];
  logic [31:0] d_mem_addr  [N];
  logic [31:0] d_mem_wdata [N];
  logic [31:0] d_mem_rdata [N];
  logic [31:0] mem [N][64];

  for (genvar g = 0; g < N; g++) begin : g_inst
    mem_bus_arbiter_if #(.AW(32), .DW(32)) bus ();
    assign bus.cpu_req   = cpu_req_v[g];
    assign bus.cpu_we    = cpu_we;
    assign bus.cpu_addr  = cpu_addr;
    assign bus.cpu_wdata = cpu_wdata;
    assign bus.io_req    = io_req_v[g];
    assign bus.io_we     = io_we;
    assign bus.io_addr   = io_addr;
    assign bus.io_wdata  = io_wdata;
    assign bus.mem_rdata = mem[g][bus.mem_addr[7:2]];
    assign d_cpu_ready[g] = bus.cpu_ready;
    assign d_io_ready[g]  = bus.io_ready;
    assign d_mem_we[g]    = bus.mem_we;
    assign d_owner[g]     = bus.owner_io;
    assign d_cpu_rdata[g] = bus.cpu_rdata;
    assign d_io_rdata[g]  = bus.io_rdata;
    assign d_mem_addr[g]  = bus.mem_addr;
    assign d_mem_wdata[g] = bus.mem_wdata;
    assign d_mem_rdata[g] = bus.mem_rdata;
    mem_bus_arbiter #(
      .AW(32), .DW(32), .MEM_LAT(lat_of(g)), .STARVE_MAX(STARVE)
    ) u_dut (
      .clk   (clk),
      .reset (reset),
      .bus   (bus)
    );
  end

  int errors = 0;
  int checks = 0;

  task automatic chk(input string name, input int inst, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s inst=%0d got=%h expected=%h t=%0t", name, inst, act, exp, $time);
    end
  endtask

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // Event log filled by the monitor, read by the stimulus for literal checks
  int we_cyc [N];
  int rdy_cyc [N];
  int rdy_cnt [N];
  int cpu_rdy_cnt [N];
  int own_cnt0 = 0;
  bit log_order = 1'b0;
  bit order_q[$];

  // Model state: access phase k (-1 idle, 0..LAT in grant, LAT+1 done) and latched transaction
  int          m_k [N];
  bit          m_io [N];
  bit          m_we [N];
  logic [31:0] m_addr [N], m_wdata [N], m_crd [N], m_ird [N];
  int          m_starve [N];
  bit          m_last_io [N];
  bit          m_valid = 1'b0;

  initial begin
    for (int i = 0; i < N; i++) begin
      for (int a = 0; a < 64; a++) mem[i][a] = 32'h0;
      mem[i][20] = 32'h0000_1234;
      mem[i][22] = 32'hC0DE_0000 + 32'(i);
      we_cyc[i] = 0; rdy_cyc[i] = 0; rdy_cnt[i] = 0; cpu_rdy_cnt[i] = 0;
      m_k[i] = -1;
    end
    forever begin
      @(negedge clk);
      for (int i = 0; i < N; i++) begin
        int  lat;
        bit  creq, ireq, gio;
        lat = lat_of(i);
        if (m_valid) begin
          chk("cpu_ready", i, 32'(d_cpu_ready[i]), 32'((m_k[i] == lat + 1) && !m_io[i]));
          chk("io_ready",  i, 32'(d_io_ready[i]),  32'((m_k[i] == lat + 1) && m_io[i]));
          chk("mem_we",    i, 32'(d_mem_we[i]),    32'((m_k[i] == 0) && m_we[i]));
          chk("owner_io",  i, 32'(d_owner[i]),     32'((m_k[i] >= 0) && m_io[i]));
          chk("mem_addr",  i, d_mem_addr[i],  m_addr[i]);
          chk("mem_wdata", i, d_mem_wdata[i], m_wdata[i]);
          chk("cpu_rdata", i, d_cpu_rdata[i], m_crd[i]);
          chk("io_rdata",  i, d_io_rdata[i],  m_ird[i]);
        end
        if (d_mem_we[i] === 1'b1) we_cyc[i] = cyc;
        if (d_cpu_ready[i] === 1'b1 || d_io_ready[i] === 1'b1) begin
          rdy_cyc[i] = cyc;
          rdy_cnt[i]++;
          if (i == 0 && log_order) order_q.push_back(d_io_ready[i] === 1'b1);
        end
        if (d_cpu_ready[i] === 1'b1) cpu_rdy_cnt[i]++;
        if (i == 0 && d_owner[0] === 1'b1) own_cnt0++;
        // Advance the model across the coming rising edge
        if (reset !== 1'b1) begin
          m_k[i] = -1; m_io[i] = 1'b0; m_we[i] = 1'b0;
          m_addr[i] = 32'h0; m_wdata[i] = 32'h0; m_crd[i] = 32'h0; m_ird[i] = 32'h0;
          m_starve[i] = 0; m_last_io[i] = 1'b1;
        end else if (m_k[i] < 0) begin
          creq = cpu_req_v[i];
          ireq = io_req_v[i];
`ifdef ARB_ROUND_ROBIN_EN
          gio = ireq && (!creq || !m_last_io[i]);
`else
          gio = ireq && (!creq || m_starve[i] == STARVE);
          if (!ireq || gio) m_starve[i] = 0;
          else if (creq && m_starve[i] < STARVE) m_starve[i] = m_starve[i] + 1;
`endif
          if (creq || ireq) begin
            m_k[i] = 0; m_io[i] = gio; m_last_io[i] = gio;
            m_we[i]    = gio ? io_we    : cpu_we;
            m_addr[i]  = gio ? io_addr  : cpu_addr;
            m_wdata[i] = gio ? io_wdata : cpu_wdata;
          end
        end else if (m_k[i] < lat + 1) begin
          m_k[i]++;
          if (m_k[i] == lat + 1 && !m_we[i]) begin
            if (m_io[i]) m_ird[i] = d_mem_rdata[i];
            else m_crd[i] = d_mem_rdata[i];
          end
        end else begin
          m_k[i] = -1;
        end
        if (d_mem_we[i] === 1'b1) mem[i][d_mem_addr[i][7:2]] = d_mem_wdata[i];
      end
      if (reset === 1'b0) m_valid = 1'b1;
    end
  end

  // Each instance drops its requests in the cycle after its n-th completion from now
  task automatic run_until(input int n);
    int base [N];
    bit busy;
    int guard;
    for (int i = 0; i < N; i++) base[i] = rdy_cnt[i];
    guard = 0;
    busy  = 1'b1;
    while (busy && guard < 600) begin
      @(posedge clk); #2;
      busy = 1'b0;
      for (int i = 0; i < N; i++) begin
        if (cpu_req_v[i] || io_req_v[i]) begin
          if (rdy_cnt[i] - base[i] >= n) begin
            cpu_req_v[i] = 1'b0;
            io_req_v[i]  = 1'b0;
          end else begin
            busy = 1'b1;
          end
        end
      end
      guard++;
    end
    chk("ready_timeout", 0, 32'(busy), 32'd0);
    for (int i = 0; i < N; i++) begin
      cpu_req_v[i] = 1'b0;
      io_req_v[i]  = 1'b0;
    end
  endtask

  task automatic set_reqs(input bit c, input bit io);
    for (int i = 0; i < N; i++) begin
      cpu_req_v[i] = c;
      io_req_v[i]  = io;
    end
  endtask

  int exp_delta [N] = '{2, 4, 16};
  logic [31:0] exp_rd58 [N] = '{32'hC0DE_0000, 32'hC0DE_0001, 32'hC0DE_0002};
`ifdef ARB_ROUND_ROBIN_EN
  bit exp_order [10] = '{1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1};
`else
  bit exp_order [10] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1};
`endif

  initial begin
    int rel_cyc, base_cpu, own0, base1;
    reset = 1'b0;
    io_we = 1'b0; io_addr = 32'h0; io_wdata = 32'h0;
    cpu_we = 1'b1; cpu_addr = 32'h54; cpu_wdata = 32'd7;
    set_reqs(1'b1, 1'b0);
    repeat (3) @(posedge clk);
    #2;
    chk("rst_cpu_ready", 0, 32'(d_cpu_ready[0]), 32'd0);
    chk("rst_mem_we",    0, 32'(d_mem_we[0]),    32'd0);
    chk("rst_mem_addr",  0, d_mem_addr[0],       32'd0);
    chk("rst_owner_io",  0, 32'(d_owner[0]),     32'd0);
    reset   = 1'b1;
    rel_cyc = cyc;
    run_until(1);
    chk("first_grant_cycle", 0, 32'(we_cyc[0]), 32'(rel_cyc + 1));
    chk("write_latency",     0, 32'(rdy_cyc[0] - we_cyc[0]), 32'd2);

    cpu_we = 1'b0; cpu_addr = 32'h54; cpu_wdata = 32'h0;
    set_reqs(1'b1, 1'b0);
    run_until(1);
    for (int i = 0; i < N; i++) chk("read_54", i, d_cpu_rdata[i], 32'd7);

    base_cpu = cpu_rdy_cnt[0];
    own0     = own_cnt0;
    io_we = 1'b0; io_addr = 32'h50;
    set_reqs(1'b0, 1'b1);
    run_until(1);
    chk("io_read_50",      0, d_io_rdata[0], 32'h0000_1234);
    chk("io_owner_cycles", 0, 32'(own_cnt0 - own0), 32'd3);
    chk("io_no_cpu_ready", 0, 32'(cpu_rdy_cnt[0] - base_cpu), 32'd0);

    cpu_we = 1'b0; cpu_addr = 32'h54; io_we = 1'b0; io_addr = 32'h50;
    log_order = 1'b1;
    set_reqs(1'b1, 1'b1);
    run_until(10);
    log_order = 1'b0;
    chk("order_len", 0, 32'(order_q.size()), 32'd10);
    for (int k = 0; k < 10 && k < order_q.size(); k++)
      chk("grant_order", k, 32'(order_q[k]), 32'(exp_order[k]));

    cpu_we = 1'b1; cpu_addr = 32'h60; cpu_wdata = 32'hA5A5_0001;
    set_reqs(1'b1, 1'b0);
    run_until(1);
    for (int i = 0; i < N; i++) chk("lat_sweep", i, 32'(rdy_cyc[i] - we_cyc[i]), 32'(exp_delta[i]));
    cpu_we = 1'b0; cpu_addr = 32'h60;
    set_reqs(1'b1, 1'b0);
    run_until(1);
    for (int i = 0; i < N; i++) chk("read_60", i, d_cpu_rdata[i], 32'hA5A5_0001);
    cpu_addr = 32'h58;
    set_reqs(1'b1, 1'b0);
    run_until(1);
    for (int i = 0; i < N; i++) chk("read_58", i, d_cpu_rdata[i], exp_rd58[i]);

    cpu_we = 1'b1; cpu_addr = 32'h70; cpu_wdata = 32'd9;
    set_reqs(1'b1, 1'b0);
    @(posedge clk); #2;
    reset = 1'b0;
    set_reqs(1'b0, 1'b0);
    base1 = cpu_rdy_cnt[1];
    @(posedge clk); #2;
    chk("midrst_mem_we",   1, 32'(d_mem_we[1]), 32'd0);
    chk("midrst_mem_addr", 1, d_mem_addr[1],    32'd0);
    reset = 1'b1;
    repeat (20) @(posedge clk);
    #2;
    chk("midrst_no_ready", 1, 32'(cpu_rdy_cnt[1] - base1), 32'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog expired t=%0t", $time);
    $fatal(1, "watchdog");
  end
endmodule
